typed_stream_fifo: RTL and testbench

- Type-parameterized first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Payload type is a `parameter type T`. Storage width is $bits(T), so any packed type works: logic vectors, packed structs, enums with an explicit base type.
- Sits directly upstream of the type-parameterized consumer modules. It buffers and rate-decouples a stream of T before the consumer samples it.

---
 rtl/typed_stream_fifo.sv | 90 +++++++++
 tb/tb_typed_stream_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/typed_stream_fifo.sv
// First-word-fall-through FIFO of any packed type T with valid/ready on both sides; one-cycle push-to-output latency.
// Defining TYPED_STREAM_FIFO_PEAK_EN adds a registered high-water mark output 'peak'.
module typed_stream_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  T              in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output T              out_data,
  output logic [CW-1:0] count
`ifdef TYPED_STREAM_FIFO_PEAK_EN
  ,
  output logic [CW-1:0] peak
`endif
);

  localparam int W  = $bits(T);
  localparam int AW = CW - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("typed_stream_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full, push, pop;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign out_data  = empty ? T'('0) : T'(mem_q[rd_ptr_q[AW-1:0]]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + CW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

`ifdef TYPED_STREAM_FIFO_PEAK_EN
  logic [CW-1:0] peak_q;
  logic [CW-1:0] count_d;

  assign count_d = wr_ptr_d - rd_ptr_d;
  assign peak    = peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (flush) begin
      peak_q <= '0;
    end else if (count_d > peak_q) begin
      peak_q <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_typed_stream_fifo.sv
// Scoreboard bench for typed_stream_fifo: an 8-bit instance and a packed-struct instance.
module tb_typed_stream_fifo;

  typedef struct packed {
    logic [3:0] a;
    logic       b;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
`ifdef TYPED_STREAM_FIFO_PEAK_EN
  logic [2:0] peak;
`endif

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  pair_t      s_in_data = '0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  pair_t      s_out_data;
  logic [2:0] s_count;
`ifdef TYPED_STREAM_FIFO_PEAK_EN
  logic [2:0] s_peak;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  pair_t      sexp_q[$];

  always #5 clk = ~clk;

  typed_stream_fifo #(.T(logic [7:0]), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
`ifdef TYPED_STREAM_FIFO_PEAK_EN
    , .peak(peak)
`endif
  );

  typed_stream_fifo #(.T(pair_t), .DEPTH(4)) u_sdut (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
`ifdef TYPED_STREAM_FIFO_PEAK_EN
    , .peak(s_peak)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (count != 0 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(count), 32'd0);
  endtask

  // Stimulus side: record every accepted beat the bench drives; flush drops everything.
  always @(negedge clk) begin
    if (rst_n && flush) exp_q.delete();
    else if (rst_n && in_valid && in_ready) exp_q.push_back(in_data);
    if (rst_n && s_in_valid && s_in_ready) sexp_q.push_back(s_in_data);
  end

  // Monitor side: compare every beat the consumer takes against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb8_underflow", 32'(out_data), 32'hFFFF_FFFF);
      else chk("sb8_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (rst_n && s_out_valid && s_out_ready) begin
      if (sexp_q.size() == 0) chk("sbs_underflow", 32'(s_out_data), 32'hFFFF_FFFF);
      else chk("sbs_data", 32'(s_out_data), 32'(sexp_q.pop_front()));
    end
  end

  initial begin
    logic [7:0] vec [4];
    vec[0] = 8'hA1; vec[1] = 8'hB2; vec[2] = 8'hC3; vec[3] = 8'hD4;

    #12 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_out_data", 32'(out_data), 32'h00);
    end

    // Fill to full with the consumer stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_head", 32'(out_data), 32'hA1);
    repeat (2) tick();
    chk("stall_head_stable", 32'(out_data), 32'hA1);
    out_ready = 1'b1;
    wait_drain("drain_count");
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Full with producer and consumer both active: pop only, refill next edge.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hE0 + 8'(i);
      tick();
    end
    in_data   = 8'hE4;
    out_ready = 1'b1;
    tick();
    chk("full_pop_only_count", 32'(count), 32'd3);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
`ifdef TYPED_STREAM_FIFO_PEAK_EN
    chk("peak_before_flush", 32'(peak), 32'd4);
`endif

    // Flush at count 3 with a simultaneous push.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("preflush_count", 32'(count), 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'h00);
`ifdef TYPED_STREAM_FIFO_PEAK_EN
    chk("flush_peak", 32'(peak), 32'd0);
`endif
    tick();
    chk("flush_beat_absent", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream at count 2.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("prereset_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_data", 32'(out_data), 32'h00);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    chk("post_reset_data", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Four pushes then one pop: high-water mark stays at 4.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("peak_seq_count", 32'(count), 32'd3);
`ifdef TYPED_STREAM_FIFO_PEAK_EN
    chk("peak_seq_peak", 32'(peak), 32'd4);
`endif
    out_ready = 1'b1;
    wait_drain("final_drain");
    out_ready = 1'b0;

    // Struct payload: streaming push/pop across several pointer wraps.
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = '{a: 4'h5, b: 1'b1};
    tick();
    chk("s_first_count", 32'(s_count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      s_in_data = '{a: 4'(i), b: i[0]};
      tick();
      chk("s_stream_count", 32'(s_count), 32'd1);
    end
    s_in_valid = 1'b0;
    tick();
    chk("s_drain_count", 32'(s_count), 32'd0);
    s_out_ready = 1'b0;

    tick();
    chk("sb8_leftover", 32'(exp_q.size()), 32'd0);
    chk("sbs_leftover", 32'(sexp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
